ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 146 ++++++++++++++
 tb/tb_ps2_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 pins,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) and flags bad frames.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_stb,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;  // waiting for a start bit
    localparam logic [1:0] ST_DATA   = 2'd1;  // shifting in 8 data bits
    localparam logic [1:0] ST_PARITY = 2'd2;  // capturing the parity bit
    localparam logic [1:0] ST_STOP   = 2'd3;  // capturing the stop bit, then classify

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          clk_filt_d;
    logic          fall_evt;
    logic          bit_val;
    logic [1:0]    state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered clock only follows the pin after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt   <= '0;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            fall_evt   <= 1'b0;
            bit_val    <= 1'b0;
        end else begin
            clk_filt_d <= clk_filt;
            fall_evt   <= clk_filt_d & ~clk_filt;
            bit_val    <= data_sync[1];
            if (clk_sync[1] != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign timed_out = (to_cnt == TW'(TIMEOUT - 1));
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            code       <= 8'h00;
            code_stb   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_stb   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == ST_IDLE || fall_evt) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall_evt && !bit_val) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall_evt) begin
                        shift   <= {bit_val, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fall_evt) begin
                        par_bit <= bit_val;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall_evt) begin
                        state <= ST_IDLE;
                        if (!bit_val) begin
                            frame_err <= 1'b1;
                        end else if (^{shift, par_bit}) begin
                            code     <= shift;
                            code_stb <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A fall arriving in the expiry cycle keeps the frame alive.
            if (state != ST_IDLE && !fall_evt && timed_out) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed and randomized PS/2 frames against a frame-level reference model of ps2_rx.
module tb_ps2_rx;

    localparam int FL = 8;
    localparam int TO = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_stb;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_stb   (code_stb),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_stb = 0;
    int         n_perr = 0;
    int         n_ferr = 0;
    int         n_busy = 0;
    int         multi = 0;
    int         stb_cyc = 0;
    int         stop_cyc = 0;
    logic [7:0] stb_q[$];
    logic [7:0] exp_code = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (code_stb) begin
                n_stb++;
                stb_cyc = cyc;
                stb_q.push_back(code);
            end
            if (parity_err) n_perr++;
            if (frame_err) n_ferr++;
            if (busy) n_busy++;
            if (int'(code_stb) + int'(parity_err) + int'(frame_err) > 1) multi++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // Device-driven frame, 80 clk per bit; only the first nbits of the 11 are sent.
    task automatic send_bits(input logic [7:0] b, input logic p, input logic s, input int nbits);
        logic [10:0] f;
        f = {s, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_clk(20);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc + 1;
            wait_clk(40);
            ps2_clk = 1'b1;
            wait_clk(20);
        end
        ps2_data = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] b, input logic p, input logic s);
        int  s0, p0, f0, lat;
        logic es, ep, ef;
        s0 = n_stb; p0 = n_perr; f0 = n_ferr;
        ef = !s;
        es = s && (^{b, p} == 1'b1);
        ep = s && !es;
        if (es) exp_code = b;
        send_bits(b, p, s, 11);
        wait_clk(30);
        check("stb_count", n_stb - s0, es ? 1 : 0);
        check("perr_count", n_perr - p0, ep ? 1 : 0);
        check("ferr_count", n_ferr - f0, ef ? 1 : 0);
        check("code", code, exp_code);
        check("busy_after", busy, 0);
        if (es) begin
            check("stb_code", stb_q[stb_q.size() - 1], b);
            lat = stb_cyc - stop_cyc;
            checks++;
            assert (lat >= FL + 3 && lat <= FL + 5) else begin
                errors++;
                $error("FAIL latency: observed=%0d expected=%0d+-1", lat, FL + 4);
            end
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         mode, s0, p0, f0, b0, qs;

        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        #12;
        check("rst_code", code, 8'h00);
        check("rst_stb", code_stb, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_clk(20);

        run_frame(8'h1A, odd_par(8'h1A), 1'b1);

        s0 = n_stb; qs = stb_q.size();
        send_bits(8'hF0, odd_par(8'hF0), 1'b1, 11);
        wait_clk(80);
        send_bits(8'h2C, odd_par(8'h2C), 1'b1, 11);
        wait_clk(30);
        exp_code = 8'h2C;
        check("b2b_count", n_stb - s0, 2);
        if (stb_q.size() >= qs + 2) begin
            check("b2b_first", stb_q[qs], 8'hF0);
            check("b2b_second", stb_q[qs + 1], 8'h2C);
        end
        check("b2b_code", code, 8'h2C);

        run_frame(8'h2C, ~odd_par(8'h2C), 1'b1);
        run_frame(8'h1A, odd_par(8'h1A), 1'b0);

        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            mode = $urandom_range(0, 3);
            run_frame(rb, odd_par(rb) ^ (mode == 2), mode != 3);
        end

        f0 = n_ferr; s0 = n_stb;
        send_bits(8'hA5, odd_par(8'hA5), 1'b1, 4);
        wait_clk(5);
        check("to_busy_mid", busy, 1);
        wait_clk(700);
        check("to_ferr", n_ferr - f0, 1);
        check("to_stb", n_stb - s0, 0);
        check("to_busy", busy, 0);
        run_frame(8'h1A, odd_par(8'h1A), 1'b1);

        b0 = n_busy; s0 = n_stb; p0 = n_perr; f0 = n_ferr;
        ps2_clk = 1'b0;
        wait_clk(FL - 1);
        ps2_clk = 1'b1;
        wait_clk(100);
        check("glitch_busy", n_busy - b0, 0);
        check("glitch_pulses", (n_stb - s0) + (n_perr - p0) + (n_ferr - f0), 0);

        send_bits(8'h55, odd_par(8'h55), 1'b1, 5);
        ps2_data = 1'b1;
        wait_clk(20);
        ps2_clk = 1'b0;
        wait_clk(20);
        reset = 1'b1;
        wait_clk(3);
        exp_code = 8'h00;
        check("mrst_code", code, 8'h00);
        check("mrst_busy", busy, 0);
        check("mrst_flags", {code_stb, parity_err, frame_err}, 3'b000);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(20);
        reset = 1'b0;
        wait_clk(200);
        check("mrst_pulses", (n_stb - s0) + (n_perr - p0) + (n_ferr - f0), 0);
        run_frame(8'h12, odd_par(8'h12), 1'b1);

        check("exclusive", multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
